// File: rtl/ifu_prefetch_pkg.sv
// Shared constants and entry layout for the instruction prefetch unit.
package ifu_prefetch_pkg;

    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [5:0] ERET_OPCODE = 6'b010000;
    localparam logic [5:0] ERET_FUNCT  = 6'b011000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        exc;
        logic [4:0]  exc_type;
        logic        eret;
    } ifu_entry_t;

    localparam int ENTRY_W = $bits(ifu_entry_t);

    function automatic logic is_eret(input logic [31:0] ins);
        return (ins[31:26] == ERET_OPCODE) && ins[25] && (ins[5:0] == ERET_FUNCT);
    endfunction

endpackage

// File: rtl/ifu_queue.sv
// DEPTH-entry synchronous FIFO of tagged fetch entries; head is read straight from storage.
module ifu_queue
    import ifu_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  ifu_entry_t               push_data,
    input  logic                     pop,
    output ifu_entry_t               head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    ifu_entry_t    entries [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
            ifu_entry_t entry_reg;
            always_ff @(posedge clk) begin
                if (push && !flush && !rst && (wr_ptr_reg == AW'(gi))) begin
                    entry_reg <= push_data;
                end
            end
            assign entries[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = entries[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: PC sequencer, AdEL/eret tagging and a prefetch queue toward decode.
// Optional macro IFU_FETCH_HALT_EN stops fetching after enqueuing an exception or eret entry.
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IMEM_LIMIT = 32'h0000_6FFF,
    parameter int          DEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] ins_addr,
    output logic        ins_req,
    input  logic [31:0] ins_rd,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_ins,
    output logic        out_exc,
    output logic [4:0]  out_exc_type,
    output logic        out_eret
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   pc_reg;
    logic          halted;
    logic [CW-1:0] count;
    logic          addr_err;
    logic          fetch;
    logic          pop;
    logic          nonempty;
    ifu_entry_t    fetch_entry;
    ifu_entry_t    head;

    assign addr_err = (pc_reg[1:0] != 2'b00) || (pc_reg < IMEM_BASE) || (pc_reg > IMEM_LIMIT);

    always_comb begin
        fetch_entry          = '0;
        fetch_entry.pc       = pc_reg;
        fetch_entry.exc      = addr_err;
        fetch_entry.exc_type = addr_err ? EXC_ADEL : 5'd0;
        fetch_entry.ins      = addr_err ? 32'd0 : ins_rd;
        fetch_entry.eret     = !addr_err && is_eret(ins_rd);
    end

    // A full queue blocks fetch even when decode drains it this cycle.
    assign fetch    = !rst && !redirect && (count < CW'(DEPTH)) && !halted;
    assign nonempty = (count != '0);
    assign pop      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg <= RESET_PC;
        end else if (redirect) begin
            pc_reg <= redirect_pc;
        end else if (fetch) begin
            pc_reg <= pc_reg + 32'd4;
        end
    end

`ifdef IFU_FETCH_HALT_EN
    logic halted_reg;
    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            halted_reg <= 1'b0;
        end else if (fetch && (fetch_entry.exc || fetch_entry.eret)) begin
            halted_reg <= 1'b1;
        end
    end
    assign halted = halted_reg;
`else
    assign halted = 1'b0;
`endif

    ifu_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (fetch),
        .push_data (fetch_entry),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign ins_addr     = pc_reg;
    assign ins_req      = fetch;
    assign out_valid    = nonempty && !redirect;
    assign out_pc       = nonempty ? head.pc       : 32'd0;
    assign out_ins      = nonempty ? head.ins      : 32'd0;
    assign out_exc      = nonempty ? head.exc      : 1'b0;
    assign out_exc_type = nonempty ? head.exc_type : 5'd0;
    assign out_eret     = nonempty ? head.eret     : 1'b0;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Scoreboard bench for ifu_prefetch: a queue-based reference model predicts entries, a monitor checks them.
module tb_ifu_prefetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] BASE     = 32'h0000_3000;
    localparam logic [31:0] LIMIT    = 32'h0000_6FFF;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        exc;
        logic [4:0]  exc_type;
        logic        eret;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ins_addr;
    logic        ins_req;
    logic [31:0] ins_rd;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_ins;
    logic        out_exc;
    logic [4:0]  out_exc_type;
    logic        out_eret;

    int passed = 0;
    int total  = 0;

    exp_t        exp_q[$];
    logic [31:0] model_pc     = RESET_PC;
    logic        model_halted = 1'b0;
    logic        fetch_exp    = 1'b0;
    logic        armed        = 1'b0;

    always #5 clk = ~clk;

    ifu_prefetch #(
        .RESET_PC   (RESET_PC),
        .IMEM_BASE  (BASE),
        .IMEM_LIMIT (LIMIT),
        .DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ins_addr     (ins_addr),
        .ins_req      (ins_req),
        .ins_rd       (ins_rd),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_ins      (out_ins),
        .out_exc      (out_exc),
        .out_exc_type (out_exc_type),
        .out_eret     (out_eret)
    );

    // Instruction memory contents: an eret at 0x3008 and at a sparse address pattern, hashed words elsewhere.
    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a == 32'h0000_3008 || a[7:2] == 6'h27) return 32'h4200_0018;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign ins_rd = imem(ins_addr);

    function automatic exp_t predict(input logic [31:0] pc);
        exp_t e;
        logic bad;
        logic [31:0] w;
        bad = (pc % 4 != 0) || (pc < BASE) || (pc > LIMIT);
        w   = imem(pc);
        e.pc       = pc;
        e.exc      = bad;
        e.exc_type = bad ? 5'd4 : 5'd0;
        e.ins      = bad ? 32'd0 : w;
        e.eret     = !bad && (w[31:26] == 6'd16) && w[25] && (w[5:0] == 6'd24);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        else passed++;
    endtask

    // One stimulus cycle: drive at negedge, advance the reference model just after the rising edge.
    task automatic cycle(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
        exp_t fe;
        @(negedge clk);
        rst         = r;
        redirect    = rd;
        redirect_pc = rpc;
        out_ready   = rdy;
        fetch_exp   = !r && !rd && (exp_q.size() < DEPTH) && !model_halted;
        fe          = predict(model_pc);
        @(posedge clk);
        #1;
        if (r) begin
            exp_q.delete();
            model_pc     = RESET_PC;
            model_halted = 1'b0;
            armed        = 1'b1;
        end else if (rd) begin
            exp_q.delete();
            model_pc     = rpc;
            model_halted = 1'b0;
        end else if (fetch_exp) begin
            exp_q.push_back(fe);
            model_pc = model_pc + 32'd4;
`ifdef IFU_FETCH_HALT_EN
            if (fe.exc || fe.eret) model_halted = 1'b1;
`endif
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (armed) begin
                chk("ins_addr", ins_addr, model_pc);
                chk("ins_req", 32'(ins_req), 32'(fetch_exp));
                chk("out_valid", 32'(out_valid), 32'((exp_q.size() != 0) && !redirect));
                if (exp_q.size() == 0) begin
                    chk("empty_pc", out_pc, 32'd0);
                    chk("empty_ins", out_ins, 32'd0);
                    chk("empty_flags", {25'd0, out_exc, out_exc_type, out_eret}, 32'd0);
                end else if (!redirect && out_ready) begin
                    e = exp_q.pop_front();
                    chk("out_pc", out_pc, e.pc);
                    chk("out_ins", out_ins, e.ins);
                    chk("out_exc", 32'(out_exc), 32'(e.exc));
                    chk("out_exc_type", 32'(out_exc_type), 32'(e.exc_type));
                    chk("out_eret", 32'(out_eret), 32'(e.eret));
                    $display("pop pc=%h ins=%h exc=%0b type=%0d eret=%0b", out_pc, out_ins, out_exc, out_exc_type, out_eret);
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] targets [8];
        logic [31:0] t;
        int          rdy_pct;
        targets[0] = 32'h0000_3400;
        targets[1] = 32'h0000_3002;
        targets[2] = 32'h0000_7000;
        targets[3] = 32'h0000_2FFC;
        targets[4] = 32'h0000_6FFC;
        targets[5] = 32'hFFFF_FFF8;
        targets[6] = 32'h0000_3000;
        targets[7] = 32'h0000_3090;

        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; out_ready = 1'b0;
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        repeat (6) cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 1, 32'h0000_3400, 1);
        cycle(0, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 1);
        cycle(0, 1, 32'h0000_3002, 1);
        repeat (3) cycle(0, 0, 0, 1);
        cycle(0, 1, 32'h0000_7000, 1);
        repeat (3) cycle(0, 0, 0, 1);
        cycle(0, 1, 32'h0000_3000, 1);
        repeat (6) cycle(0, 0, 0, 1);
        cycle(0, 1, 32'h0000_3100, 0);
        repeat (2) cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        repeat (6) cycle(0, 0, 0, 1);

        rdy_pct = 70;
        for (int n = 0; n < 1500; n++) begin
            if (n % 64 == 0) rdy_pct = $urandom_range(20, 100);
            t = ($urandom_range(0, 3) == 0) ? targets[$urandom_range(0, 7)]
                                            : (32'h0000_3000 + ($urandom_range(0, 16'h0FFF) << 2));
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 11) == 0),
                  t,
                  ($urandom_range(1, 100) <= rdy_pct));
        end

        @(negedge clk);
        #4;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
